traffic_controller: RTL and testbench
=====================================

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 Parameter NS_GREEN_CYCLES, default 32, minimum north-south green duration in clk cycles.
REQ-002 Parameter EW_GREEN_CYCLES, default 16, minimum east-west green duration in clk cycles.
REQ-003 Parameter YELLOW_CYCLES, default 4, exact yellow duration in clk cycles, both directions.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 NS_VEHICLE_DETECT  input  1  north-south vehicle present, sampled on clk; level-sensitive, no edge detection.
REQ-007 EW_VEHICLE_DETECT  input  1  east-west vehicle present, sampled on clk; level-sensitive.
REQ-008 NS_RED, NS_YELLOW, NS_GREEN  output  1 each  north-south lamps, registered.
REQ-009 EW_RED, EW_YELLOW, EW_GREEN  output  1 each  east-west lamps, registered.

Function
REQ-010 The FSM SHALL have four states: S_NS_GREEN, S_NS_YELLOW, S_EW_GREEN, S_EW_YELLOW.
REQ-011 Lamp decode SHALL be: S_NS_GREEN -> NS_GREEN, EW_RED; S_NS_YELLOW -> NS_YELLOW, EW_RED; S_EW_GREEN -> NS_RED, EW_GREEN; S_EW_YELLOW -> NS_RED, EW_YELLOW.
REQ-012 Each direction SHALL have exactly one lamp lit every cycle; both directions non-red simultaneously SHALL never occur.
REQ-013 A phase counter SHALL clear to 0 on every state change and increment each cycle otherwise, saturating at phase length minus 1.
REQ-014 Counter widths SHALL be clog2 of each duration: 5 bits NS green, 4 bits EW green, 2 bits yellow at defaults.
REQ-015 S_NS_GREEN -> S_NS_YELLOW when counter == NS_GREEN_CYCLES-1 and EW_VEHICLE_DETECT == 1; else remain (counter saturated, condition re-evaluated every cycle).
REQ-016 S_NS_YELLOW -> S_EW_GREEN when counter == YELLOW_CYCLES-1, unconditionally.
REQ-017 S_EW_GREEN -> S_EW_YELLOW when counter == EW_GREEN_CYCLES-1 and (NS_VEHICLE_DETECT == 1 or EW_VEHICLE_DETECT == 0); else remain saturated.
REQ-018 S_EW_YELLOW -> S_NS_GREEN when counter == YELLOW_CYCLES-1, unconditionally.
REQ-019 Detector inputs SHALL be ignored before a phase's terminal count; toggling mid-phase SHALL not shorten any phase.
REQ-020 Both detectors high at an EW terminal count SHALL end EW green (NS priority); both low at NS terminal count SHALL hold NS green.
REQ-021 Lamp outputs SHALL change on the same edge as the state register (registered decode, no combinational path from inputs to outputs).

Reset
REQ-022 While rst is high at a clk edge: state = S_NS_GREEN, counter = 0, NS_GREEN = 1, EW_RED = 1, all other lamps 0.
REQ-023 Reset asserted mid-phase (including yellow) SHALL take effect on the next edge, abandoning the phase.
REQ-024 First edge with rst low SHALL count as cycle 1 of NS green.

Structure
REQ-025 Shared package traffic_pkg SHALL hold the state enum and default duration constants.
REQ-026 One parameterized sub-module phase_counter (WIDTH; clear, enable, saturate, terminal-count flag) SHALL be instantiated per phase length or once with muxed terminal value; implementer's choice, behaviour per REQ-013.
REQ-027 No other sub-modules; no latches; no asynchronous logic.

Verification
REQ-028 rst high 3 cycles -> NS_GREEN=1, EW_RED=1 every cycle; state S_NS_GREEN after release.
REQ-029 EW_VEHICLE_DETECT=1, NS_VEHICLE_DETECT=1 constant after reset -> NS green 32 cycles, NS yellow 4, EW green 16, EW yellow 4, NS green again at cycle 57; repeats with period 56.
REQ-030 EW_VEHICLE_DETECT=0 constant -> NS green held for 200 cycles; raising EW detect at cycle 100 -> NS_YELLOW on next edge.
REQ-031 EW detect 1, NS detect 0 -> EW green extends past 16 cycles; raise NS detect at EW cycle 25 -> EW_YELLOW next edge, then 4 cycles, then NS green.
REQ-032 NS detect toggling every 3 cycles, EW every 7 cycles -> no phase shorter than its minimum; lamp one-hot and mutual-exclusion assertions hold every cycle.
REQ-033 rst pulsed during NS yellow cycle 2 -> NS_GREEN, EW_RED on following edge; full 32-cycle NS green restarts.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the two-way traffic light controller.
package traffic_pkg;

    localparam int unsigned DEF_NS_GREEN_CYCLES = 32;
    localparam int unsigned DEF_EW_GREEN_CYCLES = 16;
    localparam int unsigned DEF_YELLOW_CYCLES   = 4;

    typedef enum logic [1:0] {
        S_NS_GREEN  = 2'd0,
        S_NS_YELLOW = 2'd1,
        S_EW_GREEN  = 2'd2,
        S_EW_YELLOW = 2'd3
    } state_t;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
    } lamps_t;

    // A one-cycle phase still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l = '0;
        case (s)
            S_NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red    = 1'b1; end
            S_NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red    = 1'b1; end
            S_EW_GREEN:  begin l.ns_red    = 1'b1; l.ew_green  = 1'b1; end
            S_EW_YELLOW: begin l.ns_red    = 1'b1; l.ew_yellow = 1'b1; end
            default:     begin l.ns_green  = 1'b1; l.ew_red    = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_controller_phase_counter.sv
// Saturating phase counter with synchronous clear and terminal-count flag.
module phase_counter #(
    parameter int unsigned     WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TERM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/traffic_controller.sv
// Two-way intersection controller: minimum-green phases extended by vehicle
// detectors, fixed yellow, registered lamp outputs.
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int unsigned NS_GREEN_CYCLES = DEF_NS_GREEN_CYCLES,
    parameter int unsigned EW_GREEN_CYCLES = DEF_EW_GREEN_CYCLES,
    parameter int unsigned YELLOW_CYCLES   = DEF_YELLOW_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic NS_VEHICLE_DETECT,
    input  logic EW_VEHICLE_DETECT,
    output logic NS_RED,
    output logic NS_YELLOW,
    output logic NS_GREEN,
    output logic EW_RED,
    output logic EW_YELLOW,
    output logic EW_GREEN
);

    localparam int unsigned NS_W = cnt_width(NS_GREEN_CYCLES);
    localparam int unsigned EW_W = cnt_width(EW_GREEN_CYCLES);
    localparam int unsigned Y_W  = cnt_width(YELLOW_CYCLES);

    state_t state_q;
    state_t state_d;
    lamps_t lamps_q;
    lamps_t lamps_d;

    logic state_chg;
    logic ns_tc;
    logic ew_tc;
    logic y_tc;

    // Every counter clears on any state change, so each phase starts at 0.
    assign state_chg = (state_d != state_q);

    phase_counter #(
        .WIDTH(NS_W),
        .TERM (NS_W'(NS_GREEN_CYCLES - 1))
    ) u_ns_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(state_chg),
        .en_i (state_q == S_NS_GREEN),
        .tc_o (ns_tc)
    );

    phase_counter #(
        .WIDTH(EW_W),
        .TERM (EW_W'(EW_GREEN_CYCLES - 1))
    ) u_ew_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(state_chg),
        .en_i (state_q == S_EW_GREEN),
        .tc_o (ew_tc)
    );

    phase_counter #(
        .WIDTH(Y_W),
        .TERM (Y_W'(YELLOW_CYCLES - 1))
    ) u_y_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(state_chg),
        .en_i ((state_q == S_NS_YELLOW) || (state_q == S_EW_YELLOW)),
        .tc_o (y_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_NS_GREEN:  if (ns_tc && EW_VEHICLE_DETECT) state_d = S_NS_YELLOW;
            S_NS_YELLOW: if (y_tc) state_d = S_EW_GREEN;
            // NS demand wins over continued EW demand at the EW terminal count.
            S_EW_GREEN:  if (ew_tc && (NS_VEHICLE_DETECT || !EW_VEHICLE_DETECT))
                             state_d = S_EW_YELLOW;
            S_EW_YELLOW: if (y_tc) state_d = S_NS_GREEN;
            default:     state_d = S_NS_GREEN;
        endcase
        lamps_d = decode_lamps(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NS_GREEN;
            lamps_q <= decode_lamps(S_NS_GREEN);
        end else begin
            state_q <= state_d;
            lamps_q <= lamps_d;
        end
    end

    assign NS_RED    = lamps_q.ns_red;
    assign NS_YELLOW = lamps_q.ns_yellow;
    assign NS_GREEN  = lamps_q.ns_green;
    assign EW_RED    = lamps_q.ew_red;
    assign EW_YELLOW = lamps_q.ew_yellow;
    assign EW_GREEN  = lamps_q.ew_green;

endmodule

// File: tb/tb_traffic_controller.sv
// Self-checking bench for traffic_controller: cycle model feeding a scoreboard,
// a table of stimulus segments with hand-derived end states, and corner sequences.
module tb_traffic_controller;

    localparam int unsigned NSG_LEN = 32;
    localparam int unsigned EWG_LEN = 16;
    localparam int unsigned Y_LEN   = 4;

    // {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN}
    localparam logic [5:0] L_NSG = 6'b001_100;
    localparam logic [5:0] L_NSY = 6'b010_100;
    localparam logic [5:0] L_EWG = 6'b100_001;
    localparam logic [5:0] L_EWY = 6'b100_010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic NS_VEHICLE_DETECT = 1'b0;
    logic EW_VEHICLE_DETECT = 1'b0;
    logic NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN;

    always #5 clk = ~clk;

    traffic_controller #(
        .NS_GREEN_CYCLES(NSG_LEN),
        .EW_GREEN_CYCLES(EWG_LEN),
        .YELLOW_CYCLES  (Y_LEN)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .NS_VEHICLE_DETECT(NS_VEHICLE_DETECT),
        .EW_VEHICLE_DETECT(EW_VEHICLE_DETECT),
        .NS_RED           (NS_RED),
        .NS_YELLOW        (NS_YELLOW),
        .NS_GREEN         (NS_GREEN),
        .EW_RED           (EW_RED),
        .EW_YELLOW        (EW_YELLOW),
        .EW_GREEN         (EW_GREEN)
    );

    typedef struct {
        logic        r;
        logic        ns;
        logic        ew;
        int unsigned cyc;
        logic [5:0]  exp;
    } vec_t;

    vec_t        vecs[22];
    logic [5:0]  exp_q[$];
    logic [5:0]  got;
    logic [5:0]  prev;
    int unsigned run;
    bit          run_valid = 1'b0;
    int          tests = 0;
    int          fails = 0;

    // Model: phase 0..3 = NSG, NSY, EWG, EWY; el = completed cycles in phase.
    int unsigned m_ph = 0;
    int unsigned m_el = 0;

    function automatic logic [5:0] ph_lamps(input int unsigned ph);
        case (ph)
            0: return L_NSG;
            1: return L_NSY;
            2: return L_EWG;
            default: return L_EWY;
        endcase
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: lamps got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_dur(input logic [5:0] lamps, input int unsigned len);
        bit ok;
        case (lamps)
            L_NSG:   ok = (len >= NSG_LEN);
            L_NSY:   ok = (len == Y_LEN);
            L_EWG:   ok = (len >= EWG_LEN);
            L_EWY:   ok = (len == Y_LEN);
            default: ok = 1'b0;
        endcase
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL phase_len: lamps %b lasted %0d cycles", lamps, len);
        end
    endtask

    task automatic step(input logic r, input logic n, input logic e);
        int unsigned len;
        bit          go;
        logic [5:0]  exp;
        @(negedge clk);
        rst = r;
        NS_VEHICLE_DETECT = n;
        EW_VEHICLE_DETECT = e;
        if (r) begin
            m_ph = 0;
            m_el = 0;
        end else begin
            len = (m_ph == 0) ? NSG_LEN : (m_ph == 2) ? EWG_LEN : Y_LEN;
            case (m_ph)
                0:       go = (m_el + 1 >= len) && e;
                2:       go = (m_el + 1 >= len) && (n || !e);
                default: go = (m_el + 1 >= len);
            endcase
            if (go) begin
                m_ph = (m_ph + 1) % 4;
                m_el = 0;
            end else begin
                m_el++;
            end
        end
        exp_q.push_back(ph_lamps(m_ph));
        @(posedge clk);
        #1;
        got = {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN};
        exp = exp_q.pop_front();
        check("scoreboard", got, exp);
        tests++;
        if (!($onehot(got[5:3]) && $onehot(got[2:0]) && (got[5] || got[2]))) begin
            fails++;
            $display("FAIL lamp_onehot: lamps got %b, need one lamp per side and a red", got);
        end
        if (r) begin
            prev = got;
            run = 1;
            run_valid = 1'b1;
        end else if (got == prev) begin
            run++;
        end else begin
            if (run_valid) check_dur(prev, run);
            prev = got;
            run = 1;
            run_valid = 1'b1;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0,   3, L_NSG};
        vecs[1]  = '{1'b0, 1'b1, 1'b1,  31, L_NSG};
        vecs[2]  = '{1'b0, 1'b1, 1'b1,   1, L_NSY};
        vecs[3]  = '{1'b0, 1'b1, 1'b1,   3, L_NSY};
        vecs[4]  = '{1'b0, 1'b1, 1'b1,   1, L_EWG};
        vecs[5]  = '{1'b0, 1'b1, 1'b1,  15, L_EWG};
        vecs[6]  = '{1'b0, 1'b1, 1'b1,   1, L_EWY};
        vecs[7]  = '{1'b0, 1'b1, 1'b1,   3, L_EWY};
        vecs[8]  = '{1'b0, 1'b1, 1'b1,   1, L_NSG};
        vecs[9]  = '{1'b0, 1'b1, 1'b1,  56, L_NSG};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 200, L_NSG};
        vecs[11] = '{1'b0, 1'b0, 1'b1,   1, L_NSY};
        vecs[12] = '{1'b0, 1'b0, 1'b1,   3, L_NSY};
        vecs[13] = '{1'b0, 1'b0, 1'b1,   1, L_EWG};
        vecs[14] = '{1'b0, 1'b0, 1'b1,  24, L_EWG};
        vecs[15] = '{1'b0, 1'b1, 1'b1,   1, L_EWY};
        vecs[16] = '{1'b0, 1'b1, 1'b1,   3, L_EWY};
        vecs[17] = '{1'b0, 1'b1, 1'b1,   1, L_NSG};
        vecs[18] = '{1'b0, 1'b0, 1'b1,  32, L_NSY};
        vecs[19] = '{1'b0, 1'b0, 1'b1,   4, L_EWG};
        vecs[20] = '{1'b0, 1'b0, 1'b0,  15, L_EWG};
        vecs[21] = '{1'b0, 1'b0, 1'b0,   1, L_EWY};

        for (int i = 0; i < 22; i++) begin
            for (int unsigned c = 0; c < vecs[i].cyc; c++) begin
                step(vecs[i].r, vecs[i].ns, vecs[i].ew);
            end
            check($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Reset during EW yellow, then during NS yellow cycle 2.
        step(1'b1, 1'b1, 1'b1);
        check("rst_in_ewy", got, L_NSG);
        for (int c = 0; c < 32; c++) step(1'b0, 1'b1, 1'b1);
        check("nsy_cycle1", got, L_NSY);
        step(1'b0, 1'b1, 1'b1);
        check("nsy_cycle2", got, L_NSY);
        step(1'b1, 1'b1, 1'b1);
        check("rst_in_nsy", got, L_NSG);
        for (int c = 0; c < 31; c++) begin
            step(1'b0, 1'b1, 1'b1);
            check("ns_restart_hold", got, L_NSG);
        end
        step(1'b0, 1'b1, 1'b1);
        check("ns_restart_end", got, L_NSY);

        // Detectors toggling mid-phase must never shorten a phase.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(1'b0, 1'(((i / 3) % 2) != 0), 1'(((i / 7) % 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
